// File: rtl/gpzda_sender_if.sv
// Byte stream from the ZDA sentence generator to the UART transmitter.
// The master presents out_data/out_valid; the slave answers with out_ready.
interface gpzda_sender_if #(
    parameter int B = 8
);
    logic [B-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/gpzda_sender.sv
// Builds one "$GPZDA,hhmmss.00,dd,mm,yyyy,00,00*CC\r\n" sentence from BCD
// fields and streams it byte by byte with its NMEA XOR checksum.
module gpzda_sender #(
    parameter int           B         = 8,
    parameter logic [6*B-1:0] ZoneField = ",00,00"
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [23:0]   time_bcd,
    input  logic [7:0]    day_bcd,
    input  logic [7:0]    month_bcd,
    input  logic [15:0]   year_bcd,
    gpzda_sender_if.master tx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        BODY,
        SUM_HI,
        SUM_LO,
        CR,
        LF
    } state_t;

    state_t       state;
    logic [B-1:0] data_q;
    logic         valid_q;
    logic [7:0]   chk_q;
    logic [5:0]   idx_q;
    logic [5:0]   idx_n;
    logic         xfer;

    logic [23:0]  time_q;
    logic [7:0]   day_q;
    logic [7:0]   month_q;
    logic [15:0]  year_q;

    logic [B-1:0] body [34];

    function automatic logic [7:0] dig(input logic [3:0] n);
        return {4'h3, n};
    endfunction

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign tx.out_data  = data_q;
    assign tx.out_valid = valid_q;
    assign xfer         = valid_q & tx.out_ready;
    assign idx_n        = idx_q + 6'd1;

    // Byte table of the sentence body, indexed by byte position.
    always_comb begin
        body[0]  = "$";
        body[1]  = "G";
        body[2]  = "P";
        body[3]  = "Z";
        body[4]  = "D";
        body[5]  = "A";
        body[6]  = ",";
        body[7]  = dig(time_q[23:20]);
        body[8]  = dig(time_q[19:16]);
        body[9]  = dig(time_q[15:12]);
        body[10] = dig(time_q[11:8]);
        body[11] = dig(time_q[7:4]);
        body[12] = dig(time_q[3:0]);
        body[13] = ".";
        body[14] = "0";
        body[15] = "0";
        body[16] = ",";
        body[17] = dig(day_q[7:4]);
        body[18] = dig(day_q[3:0]);
        body[19] = ",";
        body[20] = dig(month_q[7:4]);
        body[21] = dig(month_q[3:0]);
        body[22] = ",";
        body[23] = dig(year_q[15:12]);
        body[24] = dig(year_q[11:8]);
        body[25] = dig(year_q[7:4]);
        body[26] = dig(year_q[3:0]);
        body[27] = ZoneField[47:40];
        body[28] = ZoneField[39:32];
        body[29] = ZoneField[31:24];
        body[30] = ZoneField[23:16];
        body[31] = ZoneField[15:8];
        body[32] = ZoneField[7:0];
        body[33] = "*";
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            chk_q   <= '0;
            idx_q   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        time_q  <= time_bcd;
                        day_q   <= day_bcd;
                        month_q <= month_bcd;
                        year_q  <= year_bcd;
                        chk_q   <= '0;
                        idx_q   <= '0;
                        data_q  <= 8'h24;
                        valid_q <= 1'b1;
                        busy    <= 1'b1;
                        state   <= BODY;
                    end
                end
                BODY: begin
                    if (xfer) begin
                        // Checksum covers everything between "$" and "*".
                        if (idx_q != 6'd0 && idx_q <= 6'd32) begin
                            chk_q <= chk_q ^ data_q;
                        end
                        if (idx_q == 6'd33) begin
                            data_q <= hex(chk_q[7:4]);
                            state  <= SUM_HI;
                        end else begin
                            idx_q  <= idx_n;
                            data_q <= body[idx_n];
                        end
                    end
                end
                SUM_HI: begin
                    if (xfer) begin
                        data_q <= hex(chk_q[3:0]);
                        state  <= SUM_LO;
                    end
                end
                SUM_LO: begin
                    if (xfer) begin
                        data_q <= 8'h0D;
                        state  <= CR;
                    end
                end
                CR: begin
                    if (xfer) begin
                        data_q <= 8'h0A;
                        state  <= LF;
                    end
                end
                LF: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpzda_sender.sv
// Directed bench for gpzda_sender: sentence content, checksum, backpressure,
// input latching, start handling and reset behaviour.
module tb_gpzda_sender;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [23:0] time_bcd;
    logic [7:0]  day_bcd;
    logic [7:0]  month_bcd;
    logic [15:0] year_bcd;
    logic        busy;
    logic        done;

    gpzda_sender_if bus ();

    gpzda_sender dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .time_bcd  (time_bcd),
        .day_bcd   (day_bcd),
        .month_bcd (month_bcd),
        .year_bcd  (year_bcd),
        .tx        (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] got[$];

    localparam string S_BASIC = "$GPZDA,000000.00,01,01,2000,00,00*64";
    localparam string S_HEX   = "$GPZDA,090700.00,01,01,2000,00,00*6A";

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_fields(input logic [23:0] t, input logic [7:0] d,
                              input logic [7:0] m, input logic [15:0] y);
        time_bcd  = t;
        day_bcd   = d;
        month_bcd = m;
        year_bcd  = y;
    endtask

    // mode 0: ready=1; 1: alternating ready plus 5-cycle stall on "*";
    // 2: start pulsed mid-sentence; 3: fields changed after start;
    // 4: reset asserted while byte 20 is presented.
    task automatic run_stream(input int mode, output int cycles);
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        logic       early_done = 1'b0;
        logic       rdy;
        int         star_cnt   = 0;
        got.delete();
        cycles = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (c == 0) check("first_valid", {31'h0, bus.out_valid}, 32'h1);
            if (prev_stall)
                check("stall_hold", {23'h0, bus.out_valid, bus.out_data},
                      {23'h0, 1'b1, prev_data});
            if (done) early_done = 1'b1;
            if (mode == 2 && (c == 10 || c == 11)) start = 1'b1;
            if (mode == 3 && c == 0)
                set_fields(24'h235959, 8'h31, 8'h12, 16'h1999);
            if (mode == 4 && got.size() == 20) begin
                reset_n = 1'b0;
                bus.out_ready = 1'b1;
                break;
            end
            rdy = 1'b1;
            if (mode == 1) begin
                rdy = (c % 2 == 0);
                if (bus.out_valid && bus.out_data == 8'h2A && star_cnt < 5) begin
                    rdy = 1'b0;
                    star_cnt++;
                end
            end
            bus.out_ready = rdy;
            cycles = c + 1;
            if (bus.out_valid && rdy) got.push_back(bus.out_data);
            prev_stall = bus.out_valid && !rdy;
            prev_data  = bus.out_data;
            if (got.size() == 38) break;
        end
        check("no_early_done", {31'h0, early_done}, 32'h0);
        if (mode == 1) check("star_stalls", star_cnt, 5);
    endtask

    task automatic check_seq(input string tag, input string s);
        logic [31:0] act;
        logic [31:0] exp;
        check({tag, "_len"}, got.size(), 38);
        for (int i = 0; i < 38; i++) begin
            if (i < 36) exp = {24'h0, s[i]};
            else if (i == 36) exp = 32'h0D;
            else exp = 32'h0A;
            act = (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF;
            check($sformatf("%s_b%0d", tag, i), act, exp);
        end
    endtask

    task automatic after_done(input bit restart);
        @(negedge clock);
        check("done_pulse", {31'h0, done}, 32'h1);
        check("done_busy", {31'h0, busy}, 32'h0);
        check("done_valid", {31'h0, bus.out_valid}, 32'h0);
        if (restart) begin
            start = 1'b1;
        end else begin
            @(negedge clock);
            check("done_one_cycle", {31'h0, done}, 32'h0);
        end
    endtask

    initial begin
        int cyc;
        reset_n       = 1'b0;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        set_fields(24'h000000, 8'h01, 8'h01, 16'h2000);

        repeat (4) begin
            @(negedge clock);
            check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
            check("rst_busy", {31'h0, busy}, 32'h0);
            check("rst_done", {31'h0, done}, 32'h0);
            check("rst_data", {24'h0, bus.out_data}, 32'h0);
        end
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clock);
        check("idle_valid", {31'h0, bus.out_valid}, 32'h0);

        // Basic sentence at full rate
        start = 1'b1;
        run_stream(0, cyc);
        check("basic_cycles", cyc, 38);
        check_seq("basic", S_BASIC);
        after_done(1'b0);

        // Checksum with a hex letter
        set_fields(24'h090700, 8'h01, 8'h01, 16'h2000);
        start = 1'b1;
        run_stream(0, cyc);
        check("hex_cycles", cyc, 38);
        check_seq("hex", S_HEX);
        after_done(1'b0);

        // Backpressure
        set_fields(24'h000000, 8'h01, 8'h01, 16'h2000);
        start = 1'b1;
        run_stream(1, cyc);
        check_seq("bp", S_BASIC);
        after_done(1'b0);

        // Latched fields, then back-to-back start in the done cycle
        start = 1'b1;
        run_stream(3, cyc);
        check_seq("latch", S_BASIC);
        set_fields(24'h090700, 8'h01, 8'h01, 16'h2000);
        after_done(1'b1);

        // Start pulses mid-sentence are ignored
        run_stream(2, cyc);
        check("b2b_cycles", cyc, 38);
        check_seq("midstart", S_HEX);
        after_done(1'b0);

        // Reset while byte 20 is presented
        set_fields(24'h000000, 8'h01, 8'h01, 16'h2000);
        start = 1'b1;
        run_stream(4, cyc);
        check("abort_at", got.size(), 20);
        @(negedge clock);
        check("abort_valid", {31'h0, bus.out_valid}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_no_done", {31'h0, done}, 32'h0);
        set_fields(24'h090700, 8'h01, 8'h01, 16'h2000);
        start = 1'b1;
        run_stream(0, cyc);
        check_seq("post_rst", S_HEX);
        after_done(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
